// File: rtl/gate_pkg.sv
// Shared op-code constants and the per-bit logic primitive used by the
// gate pipeline datapath.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_MUX2 = 3'd5;
  localparam logic [2:0] OP_MUXN = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // Single-bit evaluation of the two-operand ops; callers replicate it per bit.
  function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_op_core.sv
// Combinational op evaluator sitting between the two pipeline registers:
// bitwise ops, 2:1 select and NUM_IN:1 channel select with range check.
module gate_op_core
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [2:0]              op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] ch_data,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND: begin
        for (int i = 0; i < WIDTH; i++) begin
          y[i] = gate_eval(op, a[i], b[i]);
        end
      end
      OP_MUX2: y = sel[0] ? b : a;
      OP_MUXN: begin
        // Out-of-range selects fall through with y=0 and err raised.
        err = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
          if (32'(sel) == i) begin
            y   = ch_data[i*WIDTH +: WIDTH];
            err = 1'b0;
          end
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_pipe_unit.sv
// Two-stage registered logic-op unit with valid/ready handshake on both sides.
// Stage 1 holds the captured request, stage 2 holds the evaluated result.
module gate_pipe_unit
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] ch_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  logic                    vld_p1;
  logic [2:0]              op_p1;
  logic [WIDTH-1:0]        a_p1;
  logic [WIDTH-1:0]        b_p1;
  logic [SEL_W-1:0]        sel_p1;
  logic [NUM_IN*WIDTH-1:0] ch_p1;

  logic                    vld_p2;
  logic [WIDTH-1:0]        y_p2;
  logic                    err_p2;

  logic [WIDTH-1:0]        core_y;
  logic                    core_err;
  logic                    s2_load;
  logic                    accept;

  // out_ready -> in_ready is the single combinational path through the unit.
  assign s2_load  = !vld_p2 || out_ready;
  assign in_ready = !rst && (!vld_p1 || s2_load);
  assign accept   = in_valid && in_ready;

  // Stage 1: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1  <= op;
      a_p1   <= a;
      b_p1   <= b;
      sel_p1 <= sel;
      ch_p1  <= ch_data;
    end
  end

  gate_op_core #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_core (
    .op      (op_p1),
    .a       (a_p1),
    .b       (b_p1),
    .sel     (sel_p1),
    .ch_data (ch_p1),
    .y       (core_y),
    .err     (core_err)
  );

  // Stage 2: result register and occupancy control
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      y_p2   <= '0;
      err_p2 <= 1'b0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
      end else if (s2_load) begin
        vld_p1 <= 1'b0;
      end
      if (s2_load) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          y_p2   <= core_y;
          err_p2 <= core_err;
        end
      end
    end
  end

  assign out_valid = vld_p2;
  assign y         = y_p2;
  assign err       = err_p2;

endmodule

// File: tb/tb_gate_pipe_unit.sv
// Self-checking bench for gate_pipe_unit: directed vector table, random
// traffic against a queue-based reference, stall and reset sequences.
module tb_gate_pipe_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic [1:0]  sel;
  logic [31:0] ch_data;
  logic        in_ready, out_valid, err;
  logic [7:0]  y;

  logic        in_valid3, out_ready3;
  logic [2:0]  op3;
  logic [7:0]  a3, b3;
  logic [1:0]  sel3;
  logic [23:0] ch3;
  logic        in_ready3, out_valid3, err3;
  logic [7:0]  y3;

  gate_pipe_unit #(.WIDTH(8), .NUM_IN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .sel(sel), .ch_data(ch_data), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .err(err)
  );

  gate_pipe_unit #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .op(op3),
    .a(a3), .b(b3), .sel(sel3), .ch_data(ch3), .out_valid(out_valid3),
    .out_ready(out_ready3), .y(y3), .err(err3)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  sel;
    logic [31:0] ch;
    logic [7:0]  ey;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       err;
  } res_t;

  vec_t vecs[11];
  res_t q[$];
  int checks = 0, failures = 0;
  int n_acc = 0, n_emit = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_y;
  logic prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: the op table applied with plain operators.
  function automatic res_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z,
                                 input logic [1:0] s, input logic [31:0] ch, input int nin);
    res_t r;
    int si;
    si = int'(s);
    r.y = 8'h00;
    r.err = 1'b0;
    case (o)
      3'd0: r.y = x & z;
      3'd1: r.y = x | z;
      3'd2: r.y = x ^ z;
      3'd3: r.y = ~x;
      3'd4: r.y = ~(x & z);
      3'd5: r.y = s[0] ? z : x;
      3'd6: if (si < nin) r.y = ch[si*8 +: 8]; else r.err = 1'b1;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic cycle();
    res_t e;
    #1;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_y", 32'(y), 32'(prev_y));
      chk("stall_err", 32'(err), 32'(prev_err));
    end
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_emit++;
        if (q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_y", 32'(y), 32'(e.y));
          chk("sb_err", 32'(err), 32'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        q.push_back(model(op, a, b, sel, ch_data, 4));
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_y = y;
    prev_err = err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_in();
    op = 3'($urandom_range(0, 7));
    a = 8'($urandom);
    b = 8'($urandom);
    sel = 2'($urandom);
    ch_data = $urandom;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      cycle();
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic send3(input logic [1:0] s, input logic [7:0] ey, input logic eerr);
    int n;
    op3 = 3'd6;
    sel3 = s;
    ch3 = 24'h332211;
    in_valid3 = 1'b1;
    out_ready3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid3 = 1'b0;
    n = 0;
    while (!out_valid3 && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("n3_valid", 32'(out_valid3), 32'd1);
    chk("n3_y", 32'(y3), 32'(ey));
    chk("n3_err", 32'(err3), 32'(eerr));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc0, emit0;
    vecs[0]  = '{3'd0, 8'hF0, 8'h3C, 2'd0, 32'h0,        8'h30, 1'b0};
    vecs[1]  = '{3'd1, 8'hF0, 8'h3C, 2'd0, 32'h0,        8'hFC, 1'b0};
    vecs[2]  = '{3'd2, 8'hF0, 8'h3C, 2'd0, 32'h0,        8'hCC, 1'b0};
    vecs[3]  = '{3'd3, 8'hA5, 8'h00, 2'd0, 32'h0,        8'h5A, 1'b0};
    vecs[4]  = '{3'd4, 8'hFF, 8'h0F, 2'd0, 32'h0,        8'hF0, 1'b0};
    vecs[5]  = '{3'd5, 8'h11, 8'h22, 2'd1, 32'h0,        8'h22, 1'b0};
    vecs[6]  = '{3'd5, 8'h11, 8'h22, 2'd0, 32'h0,        8'h11, 1'b0};
    vecs[7]  = '{3'd6, 8'h00, 8'h00, 2'd2, 32'h44332211, 8'h33, 1'b0};
    vecs[8]  = '{3'd7, 8'hFF, 8'h00, 2'd0, 32'h0,        8'h00, 1'b1};
    vecs[9]  = '{3'd0, 8'hFF, 8'hFF, 2'd0, 32'h0,        8'hFF, 1'b0};
    vecs[10] = '{3'd6, 8'h00, 8'h00, 2'd0, 32'h44332211, 8'h11, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 8'h0; b = 8'h0; sel = 2'd0; ch_data = 32'h0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; op3 = 3'd0; a3 = 8'h0; b3 = 8'h0;
    sel3 = 2'd0; ch3 = 24'h0;
    @(negedge clk);
    cycle();
    cycle();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);

    // Directed table: one transaction at a time, latency and value checked.
    for (int i = 0; i < 11; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      sel = vecs[i].sel; ch_data = vecs[i].ch;
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); sel = 2'($urandom);
      n = 1;
      while (!out_valid && n < 8) begin
        cycle();
        n++;
      end
      chk($sformatf("vec%0d_lat", i), 32'(n), 32'd2);
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].ey));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].eerr));
      cycle();
    end

    send3(2'd2, 8'h33, 1'b0);
    send3(2'd3, 8'h00, 1'b1);

    // Back-to-back 16 transactions at full throughput.
    acc0 = n_acc; emit0 = n_emit;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (n_acc - acc0 < 16 && n < 40) begin
      rand_in();
      cycle();
      n++;
    end
    chk("b2b_cycles", 32'(n), 32'd16);
    drain("b2b_drain");
    chk("b2b_emits", 32'(n_emit - emit0), 32'd16);

    // Output stall: only two accepts fit, outputs hold.
    acc0 = n_acc; emit0 = n_emit;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_in();
      cycle();
    end
    #1;
    chk("stall_accepts", 32'(n_acc - acc0), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    drain("stall_drain");
    chk("stall_emits", 32'(n_emit - emit0), 32'd2);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_in();
      cycle();
    end
    drain("rand_drain");
    chk("rand_balance", 32'(n_acc), 32'(n_emit));

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'd0; a = 8'hFF; b = 8'hFF;
    cycle();
    op = 3'd7;
    cycle();
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    cycle();
    q.delete();
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_y", 32'(y), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    emit0 = n_emit;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("no_stale", 32'(n_emit - emit0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
